// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: sequencer state encoding, register and field constants.
package mips_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam logic [4:0]  LINK_REG = 5'd31;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned TARGET_MSB = 25;
  localparam int unsigned TARGET_LSB = 0;
  localparam int unsigned RT0_BIT    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the sequencer and instruction memory.
interface pc_sequencer_if;
  import mips_pkg::*;

  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC selection: jump target, branch target or fall-through.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0]         pc_i,
  input  logic [TARGET_MSB:0] field_i,
  input  logic                branch_i,
  input  logic                branch_ne_i,
  input  logic                jump_i,
  input  logic                bgtz_i,
  input  logic                bltz_i,
  input  logic                blez_i,
  input  logic                bgez_i,
  input  logic                alu_zero_i,
  input  logic [31:0]         rs_data_i,
  output logic [31:0]         pc4_o,
  output logic [31:0]         next_pc_o
);

  logic [31:0] btarget;
  logic [31:0] jtarget;
  logic        rs_neg;
  logic        rs_zero;
  logic        regimm_taken;
  logic        taken;

  assign pc4_o   = pc_i + 32'd4;
  assign btarget = pc4_o + {{14{field_i[IMM_MSB]}}, field_i[IMM_MSB:IMM_LSB], 2'b00};
  assign jtarget = {pc4_o[31:28], field_i[TARGET_MSB:TARGET_LSB], 2'b00};

  assign rs_neg  = rs_data_i[31];
  assign rs_zero = ~|rs_data_i;

  always_comb begin
    regimm_taken = 1'b0;
    // bltz/bgez share an opcode; rt bit 0 disambiguates when the decoder raises both
    if (bltz_i && bgez_i) begin
      regimm_taken = field_i[RT0_BIT] ? ~rs_neg : rs_neg;
    end else begin
      regimm_taken = (bltz_i & rs_neg) | (bgez_i & ~rs_neg);
    end
  end

  assign taken = (branch_i & alu_zero_i)
               | (branch_ne_i & ~alu_zero_i)
               | (bgtz_i & ~rs_neg & ~rs_zero)
               | (blez_i & (rs_neg | rs_zero))
               | regimm_taken;

  assign next_pc_o = jump_i ? jtarget : (taken ? btarget : pc4_o);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/EXEC control, PC and instruction registers, jal link write.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  pc_sequencer_if.master      imem,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic                branch,
  input  logic                branch_ne,
  input  logic                jump,
  input  logic                jump_link,
  input  logic                bgtz,
  input  logic                bltz,
  input  logic                blez,
  input  logic                bgez,
  input  logic                alu_zero,
  input  logic [31:0]         rs_data,
  output logic [31:0]         pc,
  output logic                link_we,
  output logic [31:0]         link_data
);

  seq_state_e         state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc4;
  logic [31:0]        next_pc;

  next_pc_calc u_next_pc_calc (
    .pc_i        (pc_q),
    .field_i     (instr_q[TARGET_MSB:0]),
    .branch_i    (branch),
    .branch_ne_i (branch_ne),
    .jump_i      (jump),
    .bgtz_i      (bgtz),
    .bltz_i      (bltz),
    .blez_i      (blez),
    .bgez_i      (bgez),
    .alu_zero_i  (alu_zero),
    .rs_data_i   (rs_data),
    .pc4_o       (pc4),
    .next_pc_o   (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    imem.imem_req  = 1'b0;
    instr_valid    = 1'b0;
    link_we        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = FETCH;
      end
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        link_we     = exec_done & jump_link;
        if (exec_done) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign link_data      = pc4;

endmodule
